// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS execute stage.
// Shift-add multiply and restoring divide run on magnitudes; the signs are applied in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  // state | meaning
  // IDLE  | waiting for start; accepts mthi/mtlo
  // RUN   | 32 iterations, one bit per cycle, counter 31 -> 0
  // FIX   | apply signs, load HI/LO, pulse done
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state, state_nxt;
  logic [4:0]           cnt;
  logic                 is_div, neg_q, neg_r;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH:0]       sum, trial;
  logic                 sign_a, sign_b, div_zero;
  logic [WIDTH-1:0]     abs_a, abs_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state == FIX);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 5'd0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sign_a   = ~op[0] & src_a[WIDTH-1];
    sign_b   = ~op[0] & src_b[WIDTH-1];
    abs_a    = sign_a ? -src_a : src_a;
    abs_b    = sign_b ? -src_b : src_b;
    div_zero = op[1] && (src_b == '0);
    // acc is {partial product, multiplier} for multiply and {remainder, quotient} for divide
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
    if (is_div)
      acc_step = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                              : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 5'd0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= 5'd31;
            is_div <= op[1];
            if (div_zero) begin
              // Unsigned divide by zero leaves quotient all ones and remainder = raw dividend
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              opnd  <= '0;
              acc   <= {{WIDTH{1'b0}}, src_a};
            end else begin
              neg_q <= sign_a ^ sign_b;
              neg_r <= sign_a;
              opnd  <= op[1] ? abs_b : abs_a;
              acc   <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
            end
          end else begin
            if (mthi) hi <= src_a;
            if (mtlo) lo <= src_a;
          end
        end
        RUN: begin
          acc <= acc_step;
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
        end
        FIX: begin
          if (is_div) begin
            lo <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end else begin
            {hi, lo} <= neg_q ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
